fract_dec_phase_ctrl: RTL and testbench

FRACT_DEC_PHASE_CTRL -- requirements
Module: fract_dec_phase_ctrl

---
 rtl/fract_dec_phase_ctrl.sv | 147 ++++++++++++++
 tb/tb_fract_dec_phase_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fract_dec_phase_ctrl.sv
// Fractional-rate decimator phase controller: accumulates a 12-bit step per accepted
// input and emits a polyphase index on each carry. Optional macro: FRACT_DEC_PHASE_CTRL_STATS_EN.
module fract_dec_phase_ctrl #(
  parameter logic [7:0] SR_STEP = 8'd129,
  parameter logic [7:0] SR_CTRL = 8'd130
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_set_stb,
  input  logic [7:0]  i_set_addr,
  input  logic [31:0] i_set_data,
  input  logic        i_din_vld,
  output logic        o_din_rdy,
  output logic        o_phase_vld,
  output logic [11:0] o_phase,
  input  logic        i_phase_rdy,
  output logic [11:0] o_step,
  output logic        o_active,
  output logic [31:0] o_rb_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        enable;
  logic        pending;
  logic [11:0] shadow;
  logic [11:0] acc;
  logic [12:0] sum;
  logic        step_wr;
  logic        ctrl_wr;
  logic        soft_clr;
  logic        accept;
  logic        handshake;
  logic        run_acc;
  logic        carry;
  logic        run_en;
  logic        apply_step;
  logic        phase_vld_nxt;
  logic        unused_data;

  assign unused_data = ^i_set_data[31:12];

  // Both streams use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; valid holds its payload stable until that edge.
  assign accept    = i_din_vld && o_din_rdy;
  assign handshake = o_phase_vld && i_phase_rdy;

  assign step_wr  = i_set_stb && (i_set_addr == SR_STEP);
  assign ctrl_wr  = i_set_stb && (i_set_addr == SR_CTRL);
  assign soft_clr = ctrl_wr && i_set_data[1];

  assign run_en     = enable && (o_step != 12'd0);
  assign sum        = {1'b0, acc} + {1'b0, o_step};
  assign run_acc    = accept && (state == RUN) && !soft_clr;
  assign carry      = run_acc && sum[12];
  // The carry event is computed from the old step; the new step starts with the next input.
  assign apply_step = pending && ((state == IDLE) || carry);

  always_comb begin
    phase_vld_nxt = o_phase_vld;
    if (soft_clr)       phase_vld_nxt = 1'b0;
    else if (carry)     phase_vld_nxt = 1'b1;
    else if (handshake) phase_vld_nxt = 1'b0;
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run_en) state_nxt = RUN;
      RUN:     if (!run_en) state_nxt = phase_vld_nxt ? DRAIN : IDLE;
      DRAIN:   if (handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (soft_clr) state_nxt = IDLE;
  end

  // FSM outputs
  always_comb begin
    o_din_rdy = 1'b0;
    o_active  = 1'b0;
    case (state)
      IDLE:    o_din_rdy = 1'b1;
      RUN: begin
        o_din_rdy = !o_phase_vld || i_phase_rdy;
        o_active  = 1'b1;
      end
      DRAIN:   o_active = 1'b1;
      default: o_din_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc         <= 12'd0;
      o_phase_vld <= 1'b0;
      o_phase     <= 12'd0;
      enable      <= 1'b0;
    end else begin
      o_phase_vld <= phase_vld_nxt;
      if (carry) o_phase <= sum[11:0];
      if (ctrl_wr) enable <= i_set_data[0];
      if (soft_clr || (state == IDLE && state_nxt == RUN)) acc <= 12'd0;
      else if (run_acc) acc <= sum[11:0];
    end
  end

  // A write landing on the apply edge stays in the shadow and remains pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_step  <= 12'd0;
      shadow  <= 12'd0;
      pending <= 1'b0;
    end else begin
      if (apply_step) o_step <= shadow;
      if (step_wr) begin
        shadow  <= i_set_data[11:0];
        pending <= 1'b1;
      end else if (apply_step) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef FRACT_DEC_PHASE_CTRL_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       o_rb_data <= 32'd0;
    else if (soft_clr)  o_rb_data <= 32'd0;
    else if (handshake) o_rb_data <= o_rb_data + 32'd1;
  end
`else
  assign o_rb_data = 32'd0;
`endif

endmodule

// File: tb/tb_fract_dec_phase_ctrl.sv
// Directed self-checking bench for fract_dec_phase_ctrl; expected phases are hand-computed
// from the accumulator arithmetic (acc + step, carry out of bit 12).
module tb_fract_dec_phase_ctrl;

  localparam logic [7:0] SR_STEP = 8'd129;
  localparam logic [7:0] SR_CTRL = 8'd130;
`ifdef FRACT_DEC_PHASE_CTRL_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_set_stb = 1'b0;
  logic [7:0]  i_set_addr = 8'd0;
  logic [31:0] i_set_data = 32'd0;
  logic        i_din_vld = 1'b0;
  logic        o_din_rdy;
  logic        o_phase_vld;
  logic [11:0] o_phase;
  logic        i_phase_rdy = 1'b1;
  logic [11:0] o_step;
  logic        o_active;
  logic [31:0] o_rb_data;

  int n_chk  = 0;
  int n_pass = 0;

  fract_dec_phase_ctrl #(.SR_STEP(SR_STEP), .SR_CTRL(SR_CTRL)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_set_stb(i_set_stb), .i_set_addr(i_set_addr), .i_set_data(i_set_data),
    .i_din_vld(i_din_vld), .o_din_rdy(o_din_rdy),
    .o_phase_vld(o_phase_vld), .o_phase(o_phase), .i_phase_rdy(i_phase_rdy),
    .o_step(o_step), .o_active(o_active), .o_rb_data(o_rb_data)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  // Driver tasks: inputs change 1 ns after a rising edge, outputs are read there too
  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    i_set_stb = 1'b1; i_set_addr = a; i_set_data = d;
    cycle();
    i_set_stb = 1'b0; i_set_addr = 8'd0; i_set_data = 32'd0;
  endtask

  task automatic start_run(input logic [11:0] s);
    write_reg(SR_STEP, {20'hABCDE, s});
    write_reg(SR_CTRL, 32'd1);
    cycle();
  endtask

  task automatic stop_run();
    i_din_vld = 1'b0; i_phase_rdy = 1'b1;
    cycle();
    write_reg(SR_CTRL, 32'd0);
    cycle();
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (o_din_rdy !== 1'b1) $display("FAIL reset_din_rdy got=%0b exp=1", o_din_rdy); else n_pass++;
    n_chk++; if (o_phase_vld !== 1'b0) $display("FAIL reset_phase_vld got=%0b exp=0", o_phase_vld); else n_pass++;
    n_chk++; if (o_phase !== 12'd0) $display("FAIL reset_phase got=%0d exp=0", o_phase); else n_pass++;
    n_chk++; if (o_step !== 12'd0) $display("FAIL reset_step got=%0d exp=0", o_step); else n_pass++;
    n_chk++; if (o_active !== 1'b0) $display("FAIL reset_active got=%0b exp=0", o_active); else n_pass++;
    n_chk++; if (o_rb_data !== 32'd0) $display("FAIL reset_rb got=%0d exp=0", o_rb_data); else n_pass++;
    #21 i_rst_n = 1'b1;
    cycle();
    n_chk++; if (o_active !== 1'b0) $display("FAIL post_reset_active got=%0b exp=0", o_active); else n_pass++;
  endtask

  task automatic test_step_shadow();
    write_reg(SR_STEP, 32'd100);
    n_chk++; if (o_step !== 12'd0) $display("FAIL shadow_first got=%0d exp=0", o_step); else n_pass++;
    write_reg(SR_STEP, 32'd200);
    n_chk++; if (o_step !== 12'd100) $display("FAIL shadow_apply got=%0d exp=100", o_step); else n_pass++;
    cycle();
    n_chk++; if (o_step !== 12'd200) $display("FAIL shadow_pending got=%0d exp=200", o_step); else n_pass++;
    n_chk++; if (o_active !== 1'b0) $display("FAIL shadow_idle got=%0b exp=0", o_active); else n_pass++;
  endtask

  task automatic test_rate_2048();
    start_run(12'd2048);
    n_chk++; if (o_active !== 1'b1) $display("FAIL r2048_active got=%0b exp=1", o_active); else n_pass++;
    n_chk++; if (o_step !== 12'd2048) $display("FAIL r2048_step got=%0d exp=2048", o_step); else n_pass++;
    i_phase_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      i_din_vld = 1'b1;
      cycle();
      n_chk++;
      if (o_phase_vld !== ((i % 2) == 0)) $display("FAIL r2048_vld in=%0d got=%0b exp=%0b", i, o_phase_vld, (i % 2) == 0);
      else n_pass++;
      if ((i % 2) == 0) begin
        n_chk++; if (o_phase !== 12'd0) $display("FAIL r2048_phase in=%0d got=%0d exp=0", i, o_phase); else n_pass++;
      end
    end
    stop_run();
    n_chk++; if (o_active !== 1'b0) $display("FAIL r2048_stop got=%0b exp=0", o_active); else n_pass++;
  endtask

  task automatic test_rate_3072();
    logic        ev [5];
    logic [11:0] ph [5];
    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ph = '{12'd0, 12'd2048, 12'd1024, 12'd0, 12'd0};
    start_run(12'd3072);
    i_phase_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_din_vld = 1'b1;
      cycle();
      n_chk++;
      if (o_phase_vld !== ev[i]) $display("FAIL r3072_vld in=%0d got=%0b exp=%0b", i + 1, o_phase_vld, ev[i]);
      else n_pass++;
      if (ev[i]) begin
        n_chk++;
        if (o_phase !== ph[i]) $display("FAIL r3072_phase in=%0d got=%0d exp=%0d", i + 1, o_phase, ph[i]);
        else n_pass++;
      end
    end
    stop_run();
  endtask

  task automatic test_backpressure();
    start_run(12'd3072);
    i_phase_rdy = 1'b1; i_din_vld = 1'b1;
    cycle();
    cycle();
    n_chk++; if (o_phase !== 12'd2048) $display("FAIL bp_first got=%0d exp=2048", o_phase); else n_pass++;
    i_phase_rdy = 1'b0;
    #1;
    n_chk++; if (o_din_rdy !== 1'b0) $display("FAIL bp_din_rdy got=%0b exp=0", o_din_rdy); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_chk++; if (o_phase_vld !== 1'b1) $display("FAIL bp_hold_vld k=%0d got=%0b exp=1", k, o_phase_vld); else n_pass++;
      n_chk++; if (o_phase !== 12'd2048) $display("FAIL bp_hold_phase k=%0d got=%0d exp=2048", k, o_phase); else n_pass++;
    end
    i_phase_rdy = 1'b1;
    #1;
    n_chk++; if (o_din_rdy !== 1'b1) $display("FAIL bp_resume_rdy got=%0b exp=1", o_din_rdy); else n_pass++;
    cycle();
    n_chk++; if (o_phase_vld !== 1'b1) $display("FAIL bp_next_vld got=%0b exp=1", o_phase_vld); else n_pass++;
    n_chk++; if (o_phase !== 12'd1024) $display("FAIL bp_next_phase got=%0d exp=1024", o_phase); else n_pass++;
    stop_run();
  endtask

  task automatic test_step_switch();
    logic exp_ev;
    start_run(12'd2048);
    i_phase_rdy = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      i_din_vld = 1'b1;
      if (i == 3) begin
        i_set_stb = 1'b1; i_set_addr = SR_STEP; i_set_data = 32'd1024;
      end
      cycle();
      i_set_stb = 1'b0; i_set_addr = 8'd0; i_set_data = 32'd0;
      exp_ev = (i == 2) || (i == 4) || (i == 8) || (i == 12);
      n_chk++;
      if (o_phase_vld !== exp_ev) $display("FAIL sw_vld in=%0d got=%0b exp=%0b", i, o_phase_vld, exp_ev);
      else n_pass++;
      if (exp_ev) begin
        n_chk++; if (o_phase !== 12'd0) $display("FAIL sw_phase in=%0d got=%0d exp=0", i, o_phase); else n_pass++;
      end
      if (i == 3) begin
        n_chk++; if (o_step !== 12'd2048) $display("FAIL sw_old_step got=%0d exp=2048", o_step); else n_pass++;
      end
      if (i == 4) begin
        n_chk++; if (o_step !== 12'd1024) $display("FAIL sw_new_step got=%0d exp=1024", o_step); else n_pass++;
      end
    end
    stop_run();
  endtask

  task automatic test_drain_and_clear();
    start_run(12'd3072);
    i_phase_rdy = 1'b1; i_din_vld = 1'b1;
    cycle();
    cycle();
    i_din_vld = 1'b0; i_phase_rdy = 1'b0;
    write_reg(SR_CTRL, 32'd0);
    i_din_vld = 1'b1;
    cycle();
    n_chk++; if (o_active !== 1'b1) $display("FAIL drain_active got=%0b exp=1", o_active); else n_pass++;
    n_chk++; if (o_din_rdy !== 1'b0) $display("FAIL drain_din_rdy got=%0b exp=0", o_din_rdy); else n_pass++;
    cycle();
    n_chk++; if (o_phase !== 12'd2048) $display("FAIL drain_hold got=%0d exp=2048", o_phase); else n_pass++;
    n_chk++; if (o_din_rdy !== 1'b0) $display("FAIL drain_din_rdy2 got=%0b exp=0", o_din_rdy); else n_pass++;
    i_phase_rdy = 1'b1;
    cycle();
    n_chk++; if (o_active !== 1'b0) $display("FAIL drain_idle got=%0b exp=0", o_active); else n_pass++;
    n_chk++; if (o_phase_vld !== 1'b0) $display("FAIL drain_vld got=%0b exp=0", o_phase_vld); else n_pass++;
    n_chk++; if (o_din_rdy !== 1'b1) $display("FAIL idle_din_rdy got=%0b exp=1", o_din_rdy); else n_pass++;
    i_din_vld = 1'b0;
    // soft clear coinciding with an accept that would otherwise carry
    start_run(12'd3072);
    i_din_vld = 1'b1;
    cycle();
    write_reg(SR_CTRL, 32'd3);
    n_chk++; if (o_active !== 1'b0) $display("FAIL clr_idle got=%0b exp=0", o_active); else n_pass++;
    n_chk++; if (o_phase_vld !== 1'b0) $display("FAIL clr_vld got=%0b exp=0", o_phase_vld); else n_pass++;
    i_din_vld = 1'b0;
    cycle();
    n_chk++; if (o_active !== 1'b1) $display("FAIL clr_rerun got=%0b exp=1", o_active); else n_pass++;
    i_din_vld = 1'b1;
    cycle();
    n_chk++; if (o_phase_vld !== 1'b0) $display("FAIL clr_acc_zero got=%0b exp=0", o_phase_vld); else n_pass++;
    cycle();
    n_chk++; if (o_phase_vld !== 1'b1) $display("FAIL clr_ev_vld got=%0b exp=1", o_phase_vld); else n_pass++;
    n_chk++; if (o_phase !== 12'd2048) $display("FAIL clr_ev_phase got=%0d exp=2048", o_phase); else n_pass++;
    stop_run();
  endtask

  task automatic test_stats();
    logic [31:0] exp_rb;
    exp_rb = STATS_ON ? 32'd10 : 32'd0;
    write_reg(SR_CTRL, 32'd2);
    n_chk++; if (o_rb_data !== 32'd0) $display("FAIL stats_start got=%0d exp=0", o_rb_data); else n_pass++;
    start_run(12'd2048);
    i_phase_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_din_vld = 1'b1;
      cycle();
    end
    i_din_vld = 1'b0;
    cycle();
    n_chk++; if (o_rb_data !== exp_rb) $display("FAIL stats_count got=%0d exp=%0d", o_rb_data, exp_rb); else n_pass++;
    write_reg(SR_CTRL, 32'd2);
    n_chk++; if (o_rb_data !== 32'd0) $display("FAIL stats_clear got=%0d exp=0", o_rb_data); else n_pass++;
    n_chk++; if (o_active !== 1'b0) $display("FAIL stats_idle got=%0b exp=0", o_active); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_step_shadow();
    test_rate_2048();
    test_rate_3072();
    test_backpressure();
    test_step_switch();
    test_drain_and_clear();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
